// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ==========================================================================
// mem_access_unit_pkg: shared dBUS types, size encodings, helpers  rev 1.0
// ==========================================================================
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  localparam logic [1:0] c_F3_SIZE_B = 2'd0;
  localparam logic [1:0] c_F3_SIZE_H = 2'd1;
  localparam logic [1:0] c_F3_SIZE_W = 2'd2;
  localparam logic [1:0] c_F3_SIZE_D = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic logic [7:0] size_mask(input msize_t sz);
    logic [7:0] m;
    case (sz)
      MSIZE1:  m = 8'h01;
      MSIZE2:  m = 8'h03;
      MSIZE4:  m = 8'h0F;
      MSIZE8:  m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] a, input msize_t sz);
    logic ok;
    case (sz)
      MSIZE1:  ok = 1'b1;
      MSIZE2:  ok = (a[0] == 1'b0);
      MSIZE4:  ok = (a[1:0] == 2'b00);
      MSIZE8:  ok = (a == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// ==========================================================================
// load_extend: byte-lane extraction and sign/zero extension of load data  rev 1.0
// ==========================================================================
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [2:0]  i_offset,
  input  msize_t      i_size,
  input  logic        i_zext,
  output logic [63:0] o_data
);

  logic [63:0] w_shift;

  assign w_shift = i_data >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shift;
    case (i_size)
      MSIZE1: o_data = i_zext ? {56'd0, w_shift[7:0]}
                              : {{56{w_shift[7]}}, w_shift[7:0]};
      MSIZE2: o_data = i_zext ? {48'd0, w_shift[15:0]}
                              : {{48{w_shift[15]}}, w_shift[15:0]};
      MSIZE4: o_data = i_zext ? {32'd0, w_shift[31:0]}
                              : {{32{w_shift[31]}}, w_shift[31:0]};
      MSIZE8: o_data = w_shift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ==========================================================================
// mem_access_unit: load/store sequencer over one dBUS shared with the MMU  rev 1.0
// ==========================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [63:0] i_vaddr,
  input  logic [63:0] i_wdata,
  output logic        o_mmu_wait,
  input  logic        i_mmu_ok,
  input  logic [63:0] i_phyaddr,
  input  dbus_req_t   i_mmu_dreq,
  output dbus_resp_t  o_mmu_dresp,
  output dbus_req_t   o_dreq,
  input  dbus_resp_t  i_dresp,
  output logic        o_done,
  output logic [63:0] o_rdata,
  output logic        o_misalign
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XLATE  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_is_load;
  logic        r_is_store;
  logic        r_zext;
  logic        r_misalign;
  msize_t      r_size;
  logic [63:0] r_vaddr;
  logic [63:0] r_wdata;
  logic [63:0] r_paddr;
  logic [63:0] r_rdata;

  msize_t      w_req_size;
  logic        w_op_valid;
  logic        w_aligned;
  logic        w_launch;
  logic [7:0]  w_strobe;
  logic [63:0] w_store_data;
  logic [63:0] w_load_data;
  logic        w_unused_vaddr;

  assign w_req_size     = msize_t'(i_funct3[1:0]);
  assign w_op_valid     = i_is_load | i_is_store;
  assign w_aligned      = addr_aligned(i_vaddr[2:0], w_req_size);
  assign w_launch       = (r_state == S_IDLE) & i_start & w_op_valid & w_aligned;
  assign w_strobe       = size_mask(r_size) << r_paddr[2:0];
  assign w_store_data   = r_wdata << {r_paddr[2:0], 3'b000};
  // The MMU translates from its own copy; the latched vaddr is kept for debug.
  assign w_unused_vaddr = ^r_vaddr;

  load_extend u_load_extend (
    .i_data   (i_dresp.data),
    .i_offset (r_paddr[2:0]),
    .i_size   (r_size),
    .i_zext   (r_zext),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_zext     <= 1'b0;
      r_misalign <= 1'b0;
      r_size     <= MSIZE1;
      r_vaddr    <= 64'd0;
      r_wdata    <= 64'd0;
      r_paddr    <= 64'd0;
      r_rdata    <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && i_start) begin
        r_misalign <= w_op_valid & ~w_aligned;
      end
      if (w_launch) begin
        r_is_load  <= i_is_load;
        r_is_store <= i_is_store;
        r_zext     <= i_funct3[2];
        r_size     <= w_req_size;
        r_vaddr    <= i_vaddr;
        r_wdata    <= i_wdata;
      end
      if ((r_state == S_XLATE) && i_mmu_ok) begin
        r_paddr <= i_phyaddr;
      end
      if ((r_state == S_ACCESS) && i_dresp.data_ok && r_is_load) begin
        r_rdata <= w_load_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_mmu_wait  = 1'b0;
    o_done      = 1'b0;
    o_dreq      = '0;
    o_mmu_dresp = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = w_launch ? S_XLATE : S_DONE;
        end
      end
      S_XLATE: begin
        // The MMU owns the dBUS while it walks the page table.
        o_mmu_wait  = 1'b1;
        o_dreq      = i_mmu_dreq;
        o_mmu_dresp = i_dresp;
        if (i_mmu_ok) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_dreq.valid  = 1'b1;
        o_dreq.addr   = r_paddr;
        o_dreq.size   = r_size;
        o_dreq.strobe = r_is_store ? w_strobe : 8'h00;
        o_dreq.data   = r_is_store ? w_store_data : 64'd0;
        if (i_dresp.data_ok) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_rdata    = r_rdata;
  assign o_misalign = r_misalign;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state updates on posedge clk.
REQ-002 SHALL have reset, input, 1, synchronous, active-high.
REQ-003 SHALL have start, input, 1, one-cycle pulse launching a memory op; sampled only in IDLE.
REQ-004 SHALL have is_load / is_store, input, 1 each, op kind; never both high.
REQ-005 SHALL have funct3, input, 3; [1:0] = size (0=B,1=H,2=W,3=D); [2] = 1 means zero-extend load.
REQ-006 SHALL have vaddr, input, 64, virtual address; wdata, input, 64, store data right-aligned.
REQ-007 SHALL have mmu_wait, output, 1, translation request to the MMU.
REQ-008 SHALL have mmu_ok, input, 1, one-cycle translation-done pulse; phyAddr, input, 64, valid with mmu_ok.
REQ-009 SHALL have mmu_dreq, input, dbus_req_t, MMU page-walk request; mmu_dresp, output, dbus_resp_t, forwarded response.
REQ-010 SHALL have dreq, output, dbus_req_t, and dresp, input, dbus_resp_t; this is the single dBUS port.
REQ-011 SHALL have done, output, 1, one-cycle completion pulse; rdata, output, 64, extended load result; misalign, output, 1, fault flag valid with done.

Function
REQ-012 SHALL implement FSM states IDLE, XLATE, ACCESS, DONE.
REQ-013 IDLE: on start with neither is_load nor is_store, SHALL go to DONE with misalign=0; rdata is unchanged.
REQ-014 IDLE: on start with vaddr not aligned to 2^funct3[1:0] bytes, SHALL go to DONE with misalign=1 and issue no bus or MMU traffic.
REQ-015 IDLE: on an aligned start, SHALL latch is_load, is_store, funct3, vaddr and wdata, then go to XLATE.
REQ-016 XLATE: SHALL drive mmu_wait=1, drive dreq combinationally equal to mmu_dreq, and drive mmu_dresp equal to dresp.
REQ-017 XLATE: on mmu_ok, SHALL latch phyAddr as paddr, drop mmu_wait in the following cycle, and go to ACCESS.
REQ-018 Outside XLATE, SHALL drive mmu_dresp.data_ok=0 and addr_ok=0, and ignore mmu_dreq.
REQ-019 ACCESS: SHALL hold dreq.valid=1 with addr=paddr and size=funct3[1:0] until dresp.data_ok.
REQ-020 ACCESS store: strobe = size mask ({1,3,15,255} for B/H/W/D) << paddr[2:0]; data = wdata << (8*paddr[2:0]).
REQ-021 ACCESS load: strobe = 0; dreq.data is don't-care.
REQ-022 On data_ok in ACCESS: SHALL drop dreq.valid in the next cycle and go to DONE.
REQ-023 On data_ok for a load: rdata = (dresp.data >> 8*paddr[2:0]) truncated to the access size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
REQ-024 DONE: SHALL pulse done=1 for exactly one cycle and return to IDLE; rdata SHALL hold until the next load completes.
REQ-025 SHALL ignore start in any state other than IDLE; a start pulse arriving in the DONE cycle is lost.
REQ-026 Latency (M-mode/bare path, MMU with 2-cycle ok): done SHALL assert at the earliest 1 cycle after data_ok.

Reset
REQ-027 On reset, SHALL set state=IDLE, done=0, misalign=0, mmu_wait=0, rdata=0, paddr=0, dreq.valid=0, dreq.strobe=0.
REQ-028 Reset asserted mid-operation SHALL abandon the op: dreq.valid=0 and mmu_wait=0 from the cycle after reset, and no done pulse is produced.

Structure
REQ-029 msize_t, dbus_req_t, dbus_resp_t and the funct3 size encodings SHALL come from the shared common package; the FSM state enum SHALL be local to the module.
REQ-030 Load extraction/extension SHALL be a combinational sub-module named load_extend.

Verification
REQ-031 Load, funct3=000 (LB), vaddr=0x...1003, M-mode passthrough, dresp.data=0x0000_0000_8000_0000 -> rdata=0xFFFF_FFFF_FFFF_FF80; done pulses once.
REQ-032 Store, funct3=001 (SH), paddr[2:0]=6, wdata=0xABCD -> strobe=0xC0, data=0xABCD_0000_0000_0000, valid held until data_ok.
REQ-033 Start with funct3=010 (LW), vaddr=0x1002 -> done and misalign=1 on the next cycle; dreq.valid and mmu_wait never asserted.
REQ-034 XLATE with an MMU 3-level walk -> dreq mirrors mmu_dreq each cycle; mmu_dresp.data_ok is seen by the MMU; then an ACCESS to the returned phyAddr follows.
REQ-035 LWU (funct3=110), data=0xFFFF_FFFF in the upper word, paddr[2:0]=4 -> rdata=0x0000_0000_FFFF_FFFF.
REQ-036 Reset asserted during ACCESS with valid=1 -> valid=0 and state=IDLE next cycle; no done pulse.
